// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud divisor helper.
// Used by both the transmit buffer and the receiver in uart_ctrl.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    function automatic int unsigned calc_bit_cyc(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [Width-1:0]       din,
    output logic [Width-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] DepthCnt = Depth[AddrW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge sclk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: byte strobes are queued in a FIFO and serialized onto tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       tx_flag,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int unsigned BIT_CYC = calc_bit_cyc(CLK_FREQ, BAUD);
    localparam int unsigned BaudW   = $clog2(BIT_CYC);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(BIT_CYC - 1);
    localparam logic [2:0]       LastBit  = 3'(DATA_BITS - 1);

    uart_state_e                 state_q;
    logic [BaudW-1:0]            baud_q;
    logic [2:0]                  bit_q;
    logic [7:0]                  shift_q;
    logic                        tx_q;
    logic                        overflow_q;
    logic [7:0]                  fifo_dout;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        pop;
    logic                        bit_end;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q;
`endif

    assign pop     = (state_q == StIdle) && !fifo_empty;
    assign bit_end = (baud_q == BaudLast);

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .sclk  (sclk),
        .rst   (rst),
        .push  (tx_flag),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            if (tx_flag && fifo_full && !pop) overflow_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q <= fifo_dout;
                        bit_q   <= '0;
                        state_q <= StStart;
                        tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^fifo_dout;
`endif
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= StParity;
                            tx_q    <= parity_q;
`else
                            state_q <= StStop;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= StIdle;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                    tx_q <= 1'b1;
                end
                default: begin
                    baud_q  <= '0;
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != StIdle) || (fifo_count != '0);
    assign full     = fifo_full;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf with BIT_CYC=10 and a 4-deep FIFO.
// Frame timing is predicted from the strobe cycle and the line is sampled mid-bit.
module tb_uart_tx_buf;

    localparam int unsigned BC = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME = 11 * BC;
`else
    localparam int unsigned FRAME = 10 * BC;
`endif

    logic       sclk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_flag = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;

    uart_tx_buf #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .sclk     (sclk),
        .rst      (rst),
        .tx_flag  (tx_flag),
        .tx_data  (tx_data),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [7:0] d);
        tx_flag = 1'b1;
        tx_data = d;
        tick();
        tx_flag = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
    endtask

    // Samples a frame whose start bit is predicted to begin at cycle 'fall'.
    task automatic get_frame(input int unsigned fall, output logic [7:0] d, output logic par,
                             output logic start_ok, output logic stop_ok, output logic edge_ok);
        logic pre;
        logic at;
        pre = 1'bx;
        at  = 1'bx;
        d   = '0;
        par = 1'b0;
        while (cyc < fall + 5) begin
            if (cyc == fall - 1) pre = tx;
            if (cyc == fall) at = tx;
            tick();
        end
        start_ok = (tx === 1'b0);
        for (int b = 0; b < 8; b++) begin
            ticks(BC);
            d[b] = tx;
        end
`ifdef UART_TX_PARITY_EN
        ticks(BC);
        par = tx;
`endif
        ticks(BC);
        stop_ok = (tx === 1'b1);
        edge_ok = (pre === 1'b1) && (at === 1'b0);
    endtask

    task automatic test_reset();
        logic prev;
        int   trans;
        rst = 1'b1;
        tx_flag = 1'b0;
        ticks(3);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        prev = tx;
        trans = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx !== prev) trans++;
            prev = tx;
        end
        vectors++; if (trans !== 0) begin miscompares++; $display("FAIL reset_quiet: got %0d transitions want 0", trans); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_quiet_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        logic [7:0]  b;
        int unsigned n0;
        b = 8'hA5;
        do_reset();
        n0 = cyc;
        strobe(b);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_n1_tx: got %b want 1", tx); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_n1_busy: got %b want 1", busy); end
        tick();
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_start_edge: got %b want 0", tx); end
        ticks(BC - 1);
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_start_end: got %b want 0", tx); end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (tx !== b[i]) begin miscompares++; $display("FAIL single_bit%0d: got %b want %b", i, tx, b[i]); end
            ticks(BC - 1);
        end
`ifdef UART_TX_PARITY_EN
        tick();
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_parity: got %b want 0", tx); end
        ticks(BC - 1);
`endif
        tick();
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_stop: got %b want 1", tx); end
        ticks(BC - 1);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_last: got %b want 1 at cycle %0d", busy, cyc - n0); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_drop: got %b want 0 at cycle %0d", busy, cyc - n0); end
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_idle_tx: got %b want 1", tx); end
    endtask

    task automatic test_burst();
        int unsigned s;
        int          lows;
        logic [7:0]  d;
        logic        par, st, sp, eg;
        do_reset();
        s = cyc;
        for (int k = 1; k <= 6; k++) begin
            strobe(8'(k));
            if (k == 5) begin
                vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL burst_full: got %b want 1", full); end
                vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL burst_ovf_early: got %b want 0", overflow); end
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL burst_overflow: got %b want 1", overflow); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL burst_full_after: got %b want 1", full); end
        for (int j = 0; j < 5; j++) begin
            get_frame(s + 2 + j * (FRAME + 1), d, par, st, sp, eg);
            vectors++; if (d !== 8'(j + 1)) begin miscompares++; $display("FAIL burst_data%0d: got %h want %h", j, d, 8'(j + 1)); end
            vectors++; if (!(st && sp)) begin miscompares++; $display("FAIL burst_frame%0d: got start/stop %b%b want 01", j, !st, sp); end
            if (j > 0) begin
                vectors++; if (!eg) begin miscompares++; $display("FAIL burst_gap%0d: got bad edge want 1-cycle idle", j); end
            end
        end
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        vectors++; if (lows !== 0) begin miscompares++; $display("FAIL burst_dropped: got %0d low cycles want 0", lows); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL burst_busy_end: got %b want 0", busy); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL burst_ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_push_on_pop();
        int unsigned s;
        logic [7:0]  exp_d [5];
        logic [7:0]  d;
        logic        par, st, sp, eg;
        exp_d = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h07};
        do_reset();
        s = cyc;
        for (int k = 1; k <= 5; k++) strobe(8'(k));
        while (cyc < s + 2 + FRAME) tick();
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL pop_full_before: got %b want 1", full); end
        strobe(8'h07);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL pop_overflow: got %b want 0", overflow); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL pop_full_after: got %b want 1", full); end
        for (int j = 0; j < 5; j++) begin
            get_frame(s + 2 + (j + 1) * (FRAME + 1), d, par, st, sp, eg);
            vectors++; if (d !== exp_d[j]) begin miscompares++; $display("FAIL pop_data%0d: got %h want %h", j, d, exp_d[j]); end
            vectors++; if (!(st && sp)) begin miscompares++; $display("FAIL pop_frame%0d: got start/stop %b%b want 01", j, !st, sp); end
            if (j > 0) begin
                vectors++; if (!eg) begin miscompares++; $display("FAIL pop_gap%0d: got bad edge want 1-cycle idle", j); end
            end
        end
        ticks(FRAME);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pop_busy_end: got %b want 0", busy); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL pop_ovf_end: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int unsigned s;
        int          lows;
        logic [7:0]  d;
        logic        par, st, sp, eg;
        do_reset();
        s = cyc;
        strobe(8'hFF);
        strobe(8'hAA);
        strobe(8'hBB);
        strobe(8'hCC);
        while (cyc < s + 2 + BC + 3 * BC + 5) tick();
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL mid_bit3: got %b want 1", tx); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL mid_rst_full: got %b want 0", full); end
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        vectors++; if (lows !== 0) begin miscompares++; $display("FAIL mid_flushed: got %0d low cycles want 0", lows); end
        s = cyc;
        strobe(8'h3C);
        get_frame(s + 2, d, par, st, sp, eg);
        vectors++; if (d !== 8'h3C) begin miscompares++; $display("FAIL mid_after_data: got %h want 3c", d); end
        vectors++; if (!(st && sp && eg)) begin miscompares++; $display("FAIL mid_after_frame: got start/stop/edge %b%b%b want 111", st, sp, eg); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int unsigned s;
        logic [7:0]  d;
        logic        par, st, sp, eg;
        do_reset();
        s = cyc;
        strobe(8'h07);
        get_frame(s + 2, d, par, st, sp, eg);
        vectors++; if (d !== 8'h07) begin miscompares++; $display("FAIL par07_data: got %h want 07", d); end
        vectors++; if (par !== 1'b1) begin miscompares++; $display("FAIL par07_bit: got %b want 1", par); end
        while (cyc < s + 1 + FRAME) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL par07_len_last: got %b want 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL par07_len_end: got %b want 0", busy); end
        s = cyc;
        strobe(8'h03);
        get_frame(s + 2, d, par, st, sp, eg);
        vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL par03_data: got %h want 03", d); end
        vectors++; if (par !== 1'b0) begin miscompares++; $display("FAIL par03_bit: got %b want 0", par); end
        vectors++; if (!(st && sp && eg)) begin miscompares++; $display("FAIL par03_frame: got start/stop/edge %b%b%b want 111", st, sp, eg); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_push_on_pop();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered UART transmitter for the return path of the edge-detection system. Accepts processed pixel bytes from the FIFO controller as single-cycle `tx_flag`/`tx_data` strobes, queues them in a small synchronous FIFO, and serializes them 8N1 onto `tx`. Sits between the FIFO controller and the board's UART TX pin. It absorbs bursts faster than the line rate and flags any byte lost to overflow.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s; `BIT_CYC = CLK_FREQ / BAUD` (integer division, must be ≥ 4)
- `FIFO_DEPTH`, 16, byte buffer depth, power of two, ≥ 2
- `sclk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `tx_flag`  in  1  one-cycle write strobe for `tx_data`
- `tx_data`  in  8  byte to transmit
- `tx`  out  1  serial line, idle high
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes
- `overflow`  out  1  sticky; set when a strobe is dropped

## Operation
- Write side: on `tx_flag`=1 and (not full, or pop in the same cycle), `tx_data` is pushed. On `tx_flag`=1 with full and no pop, the byte is dropped and `overflow` is set. It stays set until `rst`.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, clear the bit counter, go to START. Otherwise stay, with `tx`=1.
  - START: `tx`=0 for `BIT_CYC` cycles, then DATA.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts `BIT_CYC` cycles. After bit 7, go to PARITY or STOP.
  - PARITY: `tx`=XOR of the 8 data bits (even parity) for `BIT_CYC` cycles, then STOP.
  - STOP: `tx`=1 for `BIT_CYC` cycles, then IDLE.
- Baud counter counts 0..`BIT_CYC`-1. It wraps at the end of each bit and is held at 0 in IDLE. Its width is `$clog2(BIT_CYC)`.
- Back-to-back: if the FIFO is non-empty at STOP end, IDLE lasts exactly 1 cycle before the next START.
- FIFO count width is `$clog2(FIFO_DEPTH)+1`. Read and write pointers wrap modulo `FIFO_DEPTH`.
- `busy` = (state≠IDLE) or (count≠0).

## Timing
- Reset values: `tx`=1, `busy`=0, `full`=0, `overflow`=0. FIFO is empty and the state is IDLE.
- `tx` is registered.
- Latency, strobe to start bit:
  - Strobe in cycle N (FIFO empty, IDLE) → byte is in the FIFO at N+1.
  - Popped at N+1, and `tx` falls at N+2.
- Frame length is 10×`BIT_CYC` cycles, or 11×`BIT_CYC` with the parity macro.
- `full` and `overflow` update in the cycle after the causing edge.
- Simultaneous push and pop when full: both take effect, count is unchanged, no overflow.
- Simultaneous push and pop when empty is impossible, because a pop requires non-empty at the clock edge.
- `rst` mid-frame: next cycle `tx`=1, FIFO flushed, `overflow` cleared, and the partial frame is abandoned. The receiver sees a framing error, which is acceptable.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in, and the frame is 8E1 (11 bits).
- Macro undefined: the PARITY state and the parity XOR are absent, and the frame is 8N1 (10 bits).

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/START/DATA/PARITY/STOP).
  - `DATA_BITS`=8.
  - A constant function computing `BIT_CYC` from `CLK_FREQ`/`BAUD`.
- The same package is reused by the receiver in `uart_ctrl`.
- One sub-module, `sync_fifo`, parameterised by width and depth.
  - Ports: push, pop, din, dout, full, empty, count.
  - Read data is available combinationally from the head.
- Serializer FSM and baud counter live in `uart_tx_buf`.

## Test plan
All scenarios use `CLK_FREQ`=1000, `BAUD`=100 (`BIT_CYC`=10), `FIFO_DEPTH`=4.
- Single byte `8'hA5`, strobe at cycle 5 → `tx` low at cycle 7. Then bits 1,0,1,0,0,1,0,1 at 10-cycle spacing, stop high at cycle 97. `busy` drops at cycle 107.
- Reset → `tx`=1, `busy`=0, `full`=0, `overflow`=0. No `tx` transitions over 200 cycles without strobes.
- Burst of 6 strobes on consecutive cycles (`8'h01`..`8'h06`):
  - `8'h01` is popped immediately. `8'h02`..`8'h05` fill the FIFO, and `full`=1.
  - `8'h06` is dropped and `overflow`=1.
  - Decoded line output is 01,02,03,04,05 with 1-cycle IDLE gaps.
- Push while full in the exact cycle of a pop (IDLE after a frame) → byte accepted, `overflow` stays 0, and it is transmitted in order.
- `rst` pulsed at bit 3 of `8'hFF` with 3 bytes queued → `tx`=1 next cycle and FIFO empty. A later strobe `8'h3C` transmits cleanly.
- With `UART_TX_PARITY_EN`, send `8'h07` → parity bit 1 and frame length 110 cycles. Send `8'h03` → parity bit 0.
